// File: rtl/bp_me_pkg.sv
// Shared types for the L2 DMA demand/prefetch arbiter.
// Packets are flat vectors laid out as {write_not_read, addr}.
package bp_me_pkg;

   typedef enum logic {
      e_dma_src_demand   = 1'b0,
      e_dma_src_prefetch = 1'b1
   } e_dma_src_e;

endpackage

// File: rtl/bp_me_dma_order_queue.sv
// Order queue for issued read blocks: a small tag FIFO, the fill beat counter
// and the pop that retires a block on its last accepted beat.
module bp_me_dma_order_queue
   import bp_me_pkg::*;
#(
   parameter  int max_outstanding_p     = 4,
   parameter  int block_size_in_fills_p = 8,
   localparam int lp_cnt_w  = $clog2(max_outstanding_p + 1),
   localparam int lp_ptr_w  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1,
   localparam int lp_beat_w = $clog2(block_size_in_fills_p)
)(
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                i_push,
   input  e_dma_src_e          i_push_tag,
   input  logic                i_beat_accept,
   output e_dma_src_e          o_head_tag,
   output logic                o_empty,
   output logic [lp_cnt_w-1:0] o_count,
   output logic                o_pop
);

   localparam logic [lp_ptr_w-1:0]  lp_ptr_last  = lp_ptr_w'(max_outstanding_p - 1);
   localparam logic [lp_beat_w-1:0] lp_beat_last = lp_beat_w'(block_size_in_fills_p - 1);
   localparam logic [lp_cnt_w-1:0]  lp_cnt_max   = lp_cnt_w'(max_outstanding_p);

   e_dma_src_e           r_tags [max_outstanding_p];
   logic [lp_ptr_w-1:0]  r_wptr;
   logic [lp_ptr_w-1:0]  r_rptr;
   logic [lp_cnt_w-1:0]  r_count;
   logic [lp_beat_w-1:0] r_beat;
   logic                 w_full;
   logic                 w_push_ok;
   logic                 w_beat_ok;

   assign o_empty    = (r_count == lp_cnt_w'(0));
   assign w_full     = (r_count == lp_cnt_max);
   assign w_beat_ok  = i_beat_accept & ~o_empty;
   assign o_pop      = w_beat_ok & (r_beat == lp_beat_last);
   // A full queue still takes a push when the head retires in the same cycle.
   assign w_push_ok  = i_push & (~w_full | o_pop);
   assign o_head_tag = r_tags[r_rptr];
   assign o_count    = r_count;

   // Tag storage carries no reset; occupancy is tracked by r_count alone.
   always_ff @(posedge clk_i) begin
      if (w_push_ok) begin
         r_tags[r_wptr] <= i_push_tag;
      end
   end

   // Pointers, occupancy and beat position within the head block.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wptr  <= lp_ptr_w'(0);
         r_rptr  <= lp_ptr_w'(0);
         r_count <= lp_cnt_w'(0);
         r_beat  <= lp_beat_w'(0);
      end else begin
         if (w_push_ok) begin
            r_wptr <= (r_wptr == lp_ptr_last) ? lp_ptr_w'(0) : r_wptr + lp_ptr_w'(1);
         end
         if (o_pop) begin
            r_rptr <= (r_rptr == lp_ptr_last) ? lp_ptr_w'(0) : r_rptr + lp_ptr_w'(1);
         end
         case ({w_push_ok, o_pop})
            2'b10:   r_count <= r_count + lp_cnt_w'(1);
            2'b01:   r_count <= r_count - lp_cnt_w'(1);
            default: r_count <= r_count;
         endcase
         if (w_beat_ok) begin
            r_beat <= (r_beat == lp_beat_last) ? lp_beat_w'(0) : r_beat + lp_beat_w'(1);
         end
      end
   end

endmodule

// File: rtl/bp_me_dma_prefetch_arbiter.sv
// Per-bank L2 DMA scheduler: demand-first issue register, read-order tracking
// and fill steering. Optional duplicate-prefetch drop: BP_ME_DMA_ARB_PF_DEDUP_EN.
module bp_me_dma_prefetch_arbiter
   import bp_me_pkg::*;
#(
   parameter  int daddr_width_p         = 32,
   parameter  int fill_width_p          = 64,
   parameter  int block_size_in_fills_p = 8,
   parameter  int max_outstanding_p     = 4,
   localparam int lp_pkt_w = 1 + daddr_width_p,
   localparam int lp_cnt_w = $clog2(max_outstanding_p + 1)
)(
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [lp_pkt_w-1:0]     demand_pkt_i,
   input  logic                    demand_pkt_v_i,
   output logic                    demand_pkt_yumi_o,
   input  logic [lp_pkt_w-1:0]     pf_pkt_i,
   input  logic                    pf_pkt_v_i,
   output logic                    pf_pkt_yumi_o,
   output logic [lp_pkt_w-1:0]     dma_pkt_o,
   output logic                    dma_pkt_v_o,
   input  logic                    dma_pkt_ready_and_i,
   input  logic [fill_width_p-1:0] dma_data_i,
   input  logic                    dma_data_v_i,
   output logic                    dma_data_ready_and_o,
   output logic [fill_width_p-1:0] demand_data_o,
   output logic                    demand_data_v_o,
   input  logic                    demand_data_ready_and_i,
   output logic [fill_width_p-1:0] pf_data_o,
   output logic                    pf_data_v_o,
   input  logic                    pf_data_ready_and_i,
   output logic [lp_cnt_w-1:0]     pf_inflight_o,
   output logic                    pf_drop_o
);

   localparam int                lp_ext_w   = lp_cnt_w + 1;
   localparam logic [lp_ext_w-1:0] lp_max_ext = lp_ext_w'(max_outstanding_p);

   logic [lp_pkt_w-1:0] r_pkt;
   logic                r_pkt_v;
   e_dma_src_e          r_pkt_src;
   logic [lp_cnt_w-1:0] r_pf_inflight;

   e_dma_src_e          w_head_tag;
   logic                w_q_empty;
   logic [lp_cnt_w-1:0] w_q_count;
   logic                w_pop;
   logic                w_push;
   logic                w_r_read;
   logic [lp_ext_w-1:0] w_reserved;
   logic                w_slot_avail;
   logic                w_load_en;
   logic                w_demand_load;
   logic                w_pf_load;
   logic                w_pf_dup;
   logic                w_dst_ready;
   logic                w_beat_accept;
   logic                w_pf_pop;

   // A read parked in R already owns a slot, so it is counted before it pushes.
   assign w_r_read     = r_pkt_v & ~r_pkt[daddr_width_p];
   assign w_reserved   = {1'b0, w_q_count} + {{lp_cnt_w{1'b0}}, w_r_read};
   assign w_slot_avail = (w_reserved < lp_max_ext) | w_pop;

   assign w_load_en     = ~r_pkt_v | dma_pkt_ready_and_i;
   assign w_demand_load = ~reset_i & w_load_en & demand_pkt_v_i
                        & (demand_pkt_i[daddr_width_p] | w_slot_avail);
   assign w_pf_load     = ~reset_i & w_load_en & pf_pkt_v_i & ~demand_pkt_v_i & w_slot_avail;
   assign w_push        = r_pkt_v & dma_pkt_ready_and_i & ~r_pkt[daddr_width_p];

`ifdef BP_ME_DMA_ARB_PF_DEDUP_EN
   localparam int lp_blk_off_w = $clog2(block_size_in_fills_p * fill_width_p / 8);
   assign w_pf_dup = ~reset_i & pf_pkt_v_i & demand_pkt_v_i & ~demand_pkt_i[daddr_width_p]
                   & (demand_pkt_i[daddr_width_p-1:lp_blk_off_w] == pf_pkt_i[daddr_width_p-1:lp_blk_off_w]);
`else
   assign w_pf_dup = 1'b0;
`endif

   assign demand_pkt_yumi_o = w_demand_load;
   assign pf_pkt_yumi_o     = w_pf_load | w_pf_dup;
   assign pf_drop_o         = w_pf_dup;
   assign dma_pkt_o         = r_pkt;
   assign dma_pkt_v_o       = r_pkt_v;
   assign pf_inflight_o     = r_pf_inflight;

   assign w_dst_ready          = (w_head_tag == e_dma_src_prefetch) ? pf_data_ready_and_i
                                                                    : demand_data_ready_and_i;
   assign dma_data_ready_and_o = ~w_q_empty & w_dst_ready;
   assign w_beat_accept        = dma_data_v_i & dma_data_ready_and_o;
   assign demand_data_v_o      = dma_data_v_i & ~w_q_empty & (w_head_tag == e_dma_src_demand);
   assign pf_data_v_o          = dma_data_v_i & ~w_q_empty & (w_head_tag == e_dma_src_prefetch);
   assign demand_data_o        = dma_data_i;
   assign pf_data_o            = dma_data_i;
   assign w_pf_pop             = w_pop & (w_head_tag == e_dma_src_prefetch);

   bp_me_dma_order_queue #(
      .max_outstanding_p     (max_outstanding_p),
      .block_size_in_fills_p (block_size_in_fills_p)
   ) order_queue (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .i_push        (w_push),
      .i_push_tag    (r_pkt_src),
      .i_beat_accept (w_beat_accept),
      .o_head_tag    (w_head_tag),
      .o_empty       (w_q_empty),
      .o_count       (w_q_count),
      .o_pop         (w_pop)
   );

   // Issue register: demand takes priority on load, otherwise it drains when accepted.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_pkt     <= {lp_pkt_w{1'b0}};
         r_pkt_v   <= 1'b0;
         r_pkt_src <= e_dma_src_demand;
      end else if (w_demand_load) begin
         r_pkt     <= demand_pkt_i;
         r_pkt_v   <= 1'b1;
         r_pkt_src <= e_dma_src_demand;
      end else if (w_pf_load) begin
         r_pkt     <= pf_pkt_i;
         r_pkt_v   <= 1'b1;
         r_pkt_src <= e_dma_src_prefetch;
      end else if (dma_pkt_ready_and_i) begin
         r_pkt_v   <= 1'b0;
      end
   end

   // Prefetch blocks counted from load into R until their last beat retires.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_pf_inflight <= lp_cnt_w'(0);
      end else begin
         case ({w_pf_load, w_pf_pop})
            2'b10:   r_pf_inflight <= r_pf_inflight + lp_cnt_w'(1);
            2'b01:   r_pf_inflight <= r_pf_inflight - lp_cnt_w'(1);
            default: r_pf_inflight <= r_pf_inflight;
         endcase
      end
   end

endmodule
